// File: rtl/aurora_tx_arbiter.sv
// Packet-level round-robin arbiter from SRC_CNT AXIS sources onto one Aurora TX stream.
// Optional per-source link-loss drop counters: define AURORA_TX_ARB_DROP_CNT_EN.
module aurora_tx_arbiter #(
    parameter int SRC_CNT = 2,
    parameter int DWIDTH  = 128
) (
    input  logic                             user_clk,
    input  logic                             reset,
    input  logic                             channel_up,
    input  logic [SRC_CNT-1:0][DWIDTH-1:0]   src_tdata,
    input  logic [SRC_CNT-1:0][DWIDTH/8-1:0] src_tkeep,
    input  logic [SRC_CNT-1:0]               src_tvalid,
    input  logic [SRC_CNT-1:0]               src_tlast,
    output logic [SRC_CNT-1:0]               src_tready,
    output logic [DWIDTH-1:0]                tx_tdata,
    output logic [DWIDTH/8-1:0]              tx_tkeep,
    output logic                             tx_tvalid,
    output logic                             tx_tlast,
    input  logic                             tx_tready,
    output logic [SRC_CNT-1:0]               grant,
    output logic [SRC_CNT-1:0][15:0]         drop_cnt
);
    localparam int IW = $clog2(SRC_CNT);

    typedef enum logic [1:0] {IDLE, PASS, FLUSH} state_t;

    state_t             state, state_nxt;
    logic [SRC_CNT-1:0] grant_q, grant_nxt;
    logic [IW-1:0]      gidx, gidx_nxt;
    logic [IW-1:0]      ptr, ptr_nxt;
    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic               sel_valid, sel_last;

    assign sel_valid = src_tvalid[gidx];
    assign sel_last  = src_tlast[gidx];
    assign grant     = grant_q;

    // First valid source strictly after the last winner, wrapping.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = ptr;
        for (int k = 1; k <= SRC_CNT; k++) begin
            idx = (int'(ptr) + k) % SRC_CNT;
            if (!win_found && src_tvalid[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            gidx    <= '0;
            ptr     <= IW'(SRC_CNT - 1);
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            gidx    <= gidx_nxt;
            ptr     <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_q;
        gidx_nxt   = gidx;
        ptr_nxt    = ptr;
        tx_tdata   = '0;
        tx_tkeep   = '0;
        tx_tvalid  = 1'b0;
        tx_tlast   = 1'b0;
        src_tready = '0;
        case (state)
            IDLE: begin
                if (channel_up && win_found) begin
                    state_nxt          = PASS;
                    grant_nxt          = '0;
                    grant_nxt[win_idx] = 1'b1;
                    gidx_nxt           = win_idx;
                    ptr_nxt            = win_idx;
                end
            end
            PASS: begin
                tx_tdata         = src_tdata[gidx];
                tx_tkeep         = src_tkeep[gidx];
                tx_tvalid        = sel_valid;
                tx_tlast         = sel_last;
                src_tready[gidx] = tx_tready;
                // A completed packet wins over a simultaneous link drop.
                if (sel_valid && tx_tready && sel_last) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (!channel_up) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                src_tready[gidx] = 1'b1;
                if (sel_valid && sel_last) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs stay quiet while reset is held, whatever the old state.
        if (reset) begin
            tx_tdata   = '0;
            tx_tkeep   = '0;
            tx_tvalid  = 1'b0;
            tx_tlast   = 1'b0;
            src_tready = '0;
        end
    end

`ifdef AURORA_TX_ARB_DROP_CNT_EN
    logic drop_inc;
    assign drop_inc = (state == FLUSH) && sel_valid && sel_last;

    for (genvar s = 0; s < SRC_CNT; s++) begin : g_drop
        logic [15:0] cnt_q;
        always_ff @(posedge user_clk) begin
            if (reset)
                cnt_q <= '0;
            else if (drop_inc && gidx == IW'(s))
                cnt_q <= cnt_q + 16'd1;
        end
        assign drop_cnt[s] = cnt_q;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Self-checking bench for aurora_tx_arbiter (SRC_CNT=2, DWIDTH=32): vector table,
// directed corner sequences and random traffic against a packet-level reference model.
module tb_aurora_tx_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
`ifdef AURORA_TX_ARB_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset, channel_up, tx_tready;
    logic [N-1:0][DW-1:0]  src_tdata;
    logic [N-1:0][DW/8-1:0] src_tkeep;
    logic [N-1:0]          src_tvalid, src_tlast, src_tready, grant;
    logic [DW-1:0]         tx_tdata;
    logic [DW/8-1:0]       tx_tkeep;
    logic                  tx_tvalid, tx_tlast;
    logic [N-1:0][15:0]    drop_cnt;

    always #5 clk = ~clk;

    aurora_tx_arbiter #(.SRC_CNT(N), .DWIDTH(DW)) dut (
        .user_clk(clk), .reset(reset), .channel_up(channel_up),
        .src_tdata(src_tdata), .src_tkeep(src_tkeep), .src_tvalid(src_tvalid),
        .src_tlast(src_tlast), .src_tready(src_tready),
        .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid),
        .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .grant(grant), .drop_cnt(drop_cnt)
    );

    int errs = 0, checks = 0, cyc = 0;

    // Reference model: owner of the current packet (-1 = none), whether it is being flushed.
    int m_own = -1;
    bit m_flush = 1'b0;
    int m_ptr = N - 1;
    int m_drops[N];

    // Handshakes seen in the last step
    bit [N-1:0] hs;
    bit         tx_acc, tx_acc_last;
    logic [DW-1:0] tx_acc_data;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("grant", grant, (m_own < 0) ? 0 : (1 << m_own));
        for (int s = 0; s < N; s++) chk("drop_cnt", drop_cnt[s], DROP_EN ? m_drops[s] : 0);
        if (reset || m_own < 0) begin
            chk("tvalid_idle", tx_tvalid, 0);
            chk("tlast_idle", tx_tlast, 0);
            chk("tdata_idle", tx_tdata, 0);
            chk("tkeep_idle", tx_tkeep, 0);
            chk("sready_idle", src_tready, 0);
        end else if (m_flush) begin
            chk("tvalid_flush", tx_tvalid, 0);
            chk("sready_flush", src_tready, 1 << m_own);
        end else begin
            chk("tvalid_pass", tx_tvalid, src_tvalid[m_own]);
            chk("tlast_pass", tx_tlast, src_tlast[m_own]);
            chk("tdata_pass", tx_tdata, src_tdata[m_own]);
            chk("tkeep_pass", tx_tkeep, src_tkeep[m_own]);
            chk("sready_pass", src_tready, tx_tready ? (1 << m_own) : 0);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_own = -1; m_flush = 0; m_ptr = N - 1;
            for (int s = 0; s < N; s++) m_drops[s] = 0;
        end else if (m_own < 0) begin
            if (channel_up) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_own < 0 && src_tvalid[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
                end
                if (m_own >= 0) m_ptr = m_own;
            end
        end else if (!m_flush) begin
            if (src_tvalid[m_own] && tx_tready && src_tlast[m_own]) m_own = -1;
            else if (!channel_up) m_flush = 1;
        end else if (src_tvalid[m_own] && src_tlast[m_own]) begin
            m_drops[m_own] = (m_drops[m_own] + 1) & 16'hFFFF;
            m_own = -1;
            m_flush = 0;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        #1;
        check_outputs();
        hs          = src_tvalid & src_tready;
        tx_acc      = tx_tvalid & tx_tready;
        tx_acc_last = tx_tlast;
        tx_acc_data = tx_tdata;
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_update();
        @(negedge clk);
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        bit       cu;
        bit [1:0] vld, last;
        bit       txr;
        bit [1:0] eg;
        bit       etv, etl;
        bit [1:0] ers;
    } vec_t;

    vec_t vt[17];
    int   cnt[N];
    int   order[$];
    int   cur_src, interleave, nbeats;

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; channel_up = 1'b1; tx_tready = 1'b1;
        src_tdata = '0; src_tkeep = '0; src_tvalid = '0; src_tlast = '0;
        @(negedge clk);
        do_reset();

        // Source 0 alone: 4 beats. Then source 1: 8 beats with link loss after beat 2.
        vt[0]  = '{1, 2'b01, 2'b00, 1, 2'b00, 0, 0, 2'b00};
        vt[1]  = '{1, 2'b01, 2'b00, 1, 2'b01, 1, 0, 2'b01};
        vt[2]  = vt[1];
        vt[3]  = vt[1];
        vt[4]  = '{1, 2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01};
        vt[5]  = '{1, 2'b00, 2'b00, 1, 2'b00, 0, 0, 2'b00};
        vt[6]  = '{1, 2'b10, 2'b00, 1, 2'b00, 0, 0, 2'b00};
        vt[7]  = '{1, 2'b10, 2'b00, 1, 2'b10, 1, 0, 2'b10};
        vt[8]  = '{0, 2'b10, 2'b00, 1, 2'b10, 1, 0, 2'b10};
        for (int i = 9; i <= 13; i++) vt[i] = '{0, 2'b10, 2'b00, 1, 2'b10, 0, 0, 2'b10};
        vt[14] = '{0, 2'b10, 2'b10, 1, 2'b10, 0, 0, 2'b10};
        vt[15] = '{0, 2'b10, 2'b00, 1, 2'b00, 0, 0, 2'b00};
        vt[16] = vt[15];
        for (int i = 0; i < 17; i++) begin
            channel_up = vt[i].cu; src_tvalid = vt[i].vld; src_tlast = vt[i].last;
            tx_tready = vt[i].txr;
            for (int s = 0; s < N; s++) begin
                src_tdata[s] = {8'(s), 8'(i), 16'h5A00};
                src_tkeep[s] = 4'(i + s);
            end
            #1;
            chk("vec_grant", grant, vt[i].eg);
            chk("vec_tvalid", tx_tvalid, vt[i].etv);
            chk("vec_tlast", tx_tlast, vt[i].etl);
            chk("vec_sready", src_tready, vt[i].ers);
            step();
        end
        chk("drop_src1", drop_cnt[1], DROP_EN ? 1 : 0);
        chk("drop_src0", drop_cnt[0], 0);

        // Both sources streaming 3-beat packets: strict alternation, no interleave.
        channel_up = 1'b1; src_tvalid = '0;
        do_reset();
        cnt = '{0, 0}; order = {}; cur_src = -1; interleave = 0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            src_tvalid = 2'b11; tx_tready = 1'b1;
            for (int s = 0; s < N; s++) begin
                src_tlast[s] = (cnt[s] == 2);
                src_tdata[s] = {8'(s), 8'(cnt[s]), 16'hA5A5};
                src_tkeep[s] = 4'hF;
            end
            step();
            for (int s = 0; s < N; s++) if (hs[s]) cnt[s] = src_tlast[s] ? 0 : cnt[s] + 1;
            if (tx_acc) begin
                if (cur_src >= 0 && cur_src != int'(tx_acc_data[31:24])) interleave++;
                cur_src = tx_acc_last ? -1 : int'(tx_acc_data[31:24]);
                if (tx_acc_last) order.push_back(int'(tx_acc_data[31:24]));
            end
        end
        chk("rr_npkts", order.size(), 4);
        for (int p = 0; p < 4; p++) chk("rr_order", (p < order.size()) ? order[p] : -1, p % 2);
        chk("rr_interleave", interleave, 0);

        // tx_tready toggling during a 4-beat packet from source 0.
        src_tvalid = '0;
        do_reset();
        cnt[0] = 0; nbeats = 0; tx_tready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            src_tvalid = 2'b01; tx_tready = ~tx_tready;
            src_tlast[0] = (cnt[0] == 3);
            src_tdata[0] = {8'h00, 8'(cnt[0]), 16'h1234};
            step();
            if (hs[0]) cnt[0]++;
            if (tx_acc) begin
                chk("bp_beat", tx_acc_data[23:16], nbeats);
                nbeats++;
                if (tx_acc_last) break;
            end
        end
        chk("bp_nbeats", nbeats, 4);

        // Link down from reset: source 0 waits; grant follows channel_up rising.
        src_tvalid = '0; channel_up = 1'b0;
        do_reset();
        src_tvalid = 2'b01; src_tlast = '0;
        for (int c = 0; c < 6; c++) step();
        channel_up = 1'b1;
        step();
        #1;
        chk("cu_rise_grant", grant, 2'b01);

        // Reset mid-packet: abandoned, first grant after reset back to source 0.
        src_tvalid = '0;
        do_reset();
        src_tvalid = 2'b01; tx_tready = 1'b1;
        for (int c = 0; c < 3; c++) step();
        src_tvalid = 2'b11;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        #1;
        chk("rst_grant", grant, 2'b01);
        chk("rst_drop0", drop_cnt[0], 0);
        chk("rst_drop1", drop_cnt[1], 0);
        @(negedge clk);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            channel_up = ($urandom_range(0, 9) != 0);
            src_tvalid = 2'($urandom);
            tx_tready  = ($urandom_range(0, 9) < 7);
            for (int s = 0; s < N; s++) begin
                src_tlast[s] = ($urandom_range(0, 2) == 0);
                src_tdata[s] = $urandom;
                src_tkeep[s] = 4'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/aurora_tx_arbiter.md
AURORA_TX_ARBITER -- requirements
Module: aurora_tx_arbiter

Interface
REQ-001 Parameter SRC_CNT, default 2: number of AXIS source ports, range 2..8.
REQ-002 Parameter DWIDTH, default 128: tdata width in bits; tkeep width is DWIDTH/8.
REQ-003 user_clk  input  1: the single clock; all logic on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 channel_up  input  1: Aurora channel status, synchronous to user_clk.
REQ-006 src_tdata  input  [SRC_CNT-1:0][DWIDTH-1:0]: per-source packet data.
REQ-007 src_tkeep  input  [SRC_CNT-1:0][DWIDTH/8-1:0]: per-source byte enables.
REQ-008 src_tvalid  input  [SRC_CNT-1:0]; src_tlast  input  [SRC_CNT-1:0]; src_tready  output  [SRC_CNT-1:0]: per-source handshake.
REQ-009 tx_tdata  output  DWIDTH; tx_tkeep  output  DWIDTH/8; tx_tvalid  output  1; tx_tlast  output  1: stream to the Aurora TX port.
REQ-010 tx_tready  input  1: Aurora TX ready.
REQ-011 grant  output  [SRC_CNT-1:0]: one-hot owner of the current packet, all-zero when no owner.
REQ-012 drop_cnt  output  [SRC_CNT-1:0][15:0]: per-source count of packets flushed on link loss.

Function
REQ-013 FSM states: IDLE, PASS, FLUSH.
REQ-014 IDLE: tx_tvalid=0, src_tready=0; if channel_up=1 and any src_tvalid=1, register the winner into grant and go to PASS next cycle, giving one bubble cycle per packet.
REQ-015 Arbitration: round-robin at packet granularity; search starts at last-granted index+1 with wrap from SRC_CNT-1 to 0; after reset the pointer is SRC_CNT-1, so source 0 has first priority.
REQ-016 PASS: tx_* = src_*[g] combinationally; src_tready[g] = tx_tready; all other src_tready = 0.
REQ-017 A source is never preempted mid-packet; grant is held until a beat with tvalid & tready & tlast.
REQ-018 PASS, last beat accepted and channel_up=1: clear grant, go to IDLE.
REQ-019 PASS, channel_up=0 sampled: go to FLUSH, keeping grant; a beat accepted on that same cycle counts as delivered.
REQ-020 FLUSH: tx_tvalid=0; src_tready[g]=1; beats are discarded until a tlast beat is consumed; then drop_cnt[g] increments, grant clears, and the FSM goes to IDLE.
REQ-021 If channel_up drops in the same cycle as an accepted tlast beat in PASS, the FSM goes to IDLE and no drop is counted.
REQ-022 drop_cnt wraps from 16'hFFFF to 0.
REQ-023 The round-robin pointer updates only on entry to PASS.
REQ-024 src_tvalid deasserting mid-packet is legal: tx_tvalid follows it and the FSM stays in PASS (or FLUSH).

Reset
REQ-025 While reset=1 at a user_clk edge: state=IDLE, grant=0, pointer=SRC_CNT-1, drop_cnt=0.
REQ-026 During reset and the first cycle after it: tx_tvalid=0, tx_tlast=0, tx_tdata=0, tx_tkeep=0, src_tready=0.
REQ-027 Reset mid-packet abandons the packet with no flush and no drop count.

Configuration
REQ-028 Macro AURORA_TX_ARB_DROP_CNT_EN: when defined, drop_cnt is implemented per REQ-020 and REQ-022.
REQ-029 When AURORA_TX_ARB_DROP_CNT_EN is undefined, the drop_cnt port exists and is tied to 0, and no counter flops are inferred; all other behaviour is identical.

Verification
REQ-030 SRC_CNT=2, channel_up=1, only source 0 sends a 4-beat packet with tx_tready=1 -> grant=2'b01 on the cycle after tvalid; 4 beats on tx with tlast on beat 4; grant=0 after.
REQ-031 Both sources continuously send 3-beat packets -> tx packet order 0,1,0,1, one idle cycle between packets, no interleaving.
REQ-032 tx_tready toggles 1,0,1,0 during a 4-beat packet -> the beat is held stable while tx_tready=0; src_tready[g] mirrors tx_tready; no beat lost or duplicated.
REQ-033 channel_up drops after beat 2 of an 8-beat packet from source 1 -> tx_tvalid=0 from the next cycle; beats 3..8 consumed with src_tready[1]=1; drop_cnt[1]=1; IDLE with grant=0 while channel_up=0.
REQ-034 channel_up=0 from reset with source 0 valid -> src_tready=0 and tx_tvalid=0 indefinitely; on channel_up rising, grant=2'b01 on the next cycle.
REQ-035 reset asserted for 1 cycle mid-packet -> all outputs at REQ-026 values the next cycle; drop_cnt=0; the first grant after reset goes to source 0.
